// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic opSignedA(logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic opSignedB(logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: 1-bit-per-cycle shift-add multiplier and restoring divider on magnitudes.
module muldiv_core import muldiv_pkg::*; (
  input  logic            CLK,
  input  logic            Rst,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic [XLEN-1:0] result
);

  logic [2:0]      opQ;
  logic            negQuoQ, negRemQ;
  logic [XLEN-1:0] hiQ, loQ, bQ;

  logic            sA, sB;
  logic [XLEN-1:0] magA, magB;

  logic [XLEN:0]     mulSum;
  logic [XLEN-1:0]   mulLo;
  logic [2*XLEN-1:0] prod, prodSigned;
  logic [XLEN:0]     shifted, trial;
  logic [XLEN-1:0]   divRem, divQuo, quoSigned, remSigned;
  logic [XLEN-1:0]   hiStep, loStep;

  assign sA   = opSignedA(op) & srcA[XLEN-1];
  assign sB   = opSignedB(op) & srcB[XLEN-1];
  assign magA = sA ? -srcA : srcA;
  assign magB = sB ? -srcB : srcB;

  // Multiply: hi accumulates, the product shifts right into lo as multiplier bits retire.
  assign mulSum = {1'b0, hiQ} + (loQ[0] ? {1'b0, bQ} : '0);
  assign mulLo  = {mulSum[0], loQ[XLEN-1:1]};
  assign prod   = {mulSum[XLEN:1], mulLo};

  // Divide: hi is the partial remainder, dividend bits shift out of lo as quotient bits enter.
  assign shifted = {hiQ, loQ[XLEN-1]};
  assign trial   = shifted - {1'b0, bQ};
  assign divRem  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign divQuo  = {loQ[XLEN-2:0], ~trial[XLEN]};

  assign hiStep = opQ[2] ? divRem : mulSum[XLEN:1];
  assign loStep = opQ[2] ? divQuo : mulLo;

  assign prodSigned = negQuoQ ? -prod : prod;
  assign quoSigned  = negQuoQ ? -divQuo : divQuo;
  assign remSigned  = negRemQ ? -divRem : divRem;

  always_comb begin
    result = '0;
    unique case (opQ)
      OP_MUL:                       result = prodSigned[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prodSigned[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quoSigned;
      default:                      result = remSigned;
    endcase
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      opQ     <= OP_MUL;
      negQuoQ <= 1'b0;
      negRemQ <= 1'b0;
      hiQ     <= '0;
      loQ     <= '0;
      bQ      <= '0;
    end else if (load) begin
      opQ     <= op;
      negQuoQ <= sA ^ sB;
      negRemQ <= sA;
      hiQ     <= '0;
      loQ     <= magA;
      bQ      <= magB;
    end else if (step) begin
      hiQ <= hiStep;
      loQ <= loStep;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage M-extension controller: stalls E while the core iterates, then presents the
// result for one cycle with DoneE.
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int unsigned CNT_W = 6
) (
  input  logic            CLK,
  input  logic            Rst,
  input  logic            StartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic            FlushE,
  output logic            StallE,
  output logic            DoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic            Busy
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  stateT           stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic [XLEN-1:0] resultQ, resultD, coreResult;
  logic            load, step;
  logic            divByZero, overflow;

  assign divByZero = MulDivOpE[2] && (SrcBE == '0);
  assign overflow  = ((MulDivOpE == OP_DIV) || (MulDivOpE == OP_REM)) &&
                     (SrcAE == INT_MIN) && (SrcBE == ALL_ONES);

  muldiv_core uCore (
    .CLK    (CLK),
    .Rst    (Rst),
    .load   (load),
    .step   (step),
    .op     (MulDivOpE),
    .srcA   (SrcAE),
    .srcB   (SrcBE),
    .result (coreResult)
  );

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    resultD = resultQ;
    StallE  = 1'b0;
    DoneE   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (StartE && !FlushE) begin
          StallE = 1'b1;
          if (divByZero) begin
            resultD = MulDivOpE[1] ? SrcAE : ALL_ONES;
            stateD  = DONE;
          end else if (overflow) begin
            resultD = MulDivOpE[1] ? '0 : INT_MIN;
            stateD  = DONE;
          end else begin
            load   = 1'b1;
            cntD   = '0;
            stateD = CALC;
          end
        end
      end
      CALC: begin
        if (FlushE) begin
          stateD = IDLE;
        end else begin
          StallE = 1'b1;
          step   = 1'b1;
          cntD   = cntQ + 1'b1;
          // The core's result already reflects this final step, including sign fix-up.
          if (cntQ == LastCnt) begin
            resultD = coreResult;
            stateD  = DONE;
          end
        end
      end
      DONE: begin
        DoneE  = !FlushE;
        stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      stateQ  <= IDLE;
      cntQ    <= '0;
      resultQ <= '0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      resultQ <= resultD;
    end
  end

  assign MulDivResultE = resultQ;
  assign Busy          = (stateQ != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench with an arithmetic reference model and directed literal checks.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        Rst = 1'b0;
  logic        StartE = 1'b0;
  logic [2:0]  MulDivOpE = 3'b000;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        FlushE = 1'b0;
  logic        StallE, DoneE, Busy;
  logic [31:0] MulDivResultE;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer dut (
    .CLK           (CLK),
    .Rst           (Rst),
    .StartE        (StartE),
    .MulDivOpE     (MulDivOpE),
    .SrcAE         (SrcAE),
    .SrcBE         (SrcBE),
    .FlushE        (FlushE),
    .StallE        (StallE),
    .DoneE         (DoneE),
    .MulDivResultE (MulDivResultE),
    .Busy          (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin pu = ua * ub; return pu[31:0]; end
      3'd1: begin ps = sa * sb; return ps[63:32]; end
      3'd2: begin ps = sa * longint'(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        ps = sa / sb; return ps[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        pu = ua / ub; return pu[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        ps = sa % sb; return ps[31:0];
      end
      default: begin
        if (b == 0) return a;
        pu = ua % ub; return pu[31:0];
      end
    endcase
  endfunction

  function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (!op[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Reference model: an accepted op occupies 32 stall cycles (or none if special), then a
  // single result cycle.
  bit          mBusy = 1'b0;
  int          mLeft = 0;
  logic [31:0] mRes = '0;

  always @(negedge CLK) begin
    logic eStall, eDone, eBusy;
    if (!Rst) begin
      mBusy = 1'b0;
      check("rst_stall", {31'b0, StallE}, 32'd0);
      check("rst_done", {31'b0, DoneE}, 32'd0);
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_result", MulDivResultE, 32'd0);
    end else begin
      if (!mBusy) begin
        eStall = StartE && !FlushE;
        eDone  = 1'b0;
        eBusy  = 1'b0;
        if (eStall) begin
          mBusy = 1'b1;
          mRes  = refResult(MulDivOpE, SrcAE, SrcBE);
          mLeft = isSpecial(MulDivOpE, SrcAE, SrcBE) ? 0 : 32;
        end
      end else if (mLeft > 0) begin
        eStall = !FlushE;
        eDone  = 1'b0;
        eBusy  = 1'b1;
        if (FlushE) mBusy = 1'b0;
        else mLeft--;
      end else begin
        eStall = 1'b0;
        eDone  = !FlushE;
        eBusy  = 1'b1;
        mBusy  = 1'b0;
      end
      check("stall", {31'b0, StallE}, {31'b0, eStall});
      check("done", {31'b0, DoneE}, {31'b0, eDone});
      check("busy", {31'b0, Busy}, {31'b0, eBusy});
      if (eDone) check("result", MulDivResultE, mRes);
    end
  end

  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes, input int expLat);
    int          lat;
    logic [31:0] got;
    lat = -1;
    got = '0;
    @(posedge CLK); #1;
    StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge CLK);
      if (DoneE) begin lat = k; got = MulDivResultE; end
      @(posedge CLK); #1;
      StartE = 1'b0;
    end
    check({name, "_latency"}, lat, expLat);
    check({name, "_value"}, got, expRes);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          nDone, d1, d2, flushDones;
    logic [31:0] r1, r2;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_result", MulDivResultE, 32'd0);
    check("reset_busy", {31'b0, Busy}, 32'd0);
    Rst = 1'b1;

    runOp("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    runOp("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    runOp("mulh_m1_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    runOp("mulhsu_m1_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    runOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    runOp("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Back-to-back: StartE stays high, second op accepted in the IDLE cycle after DoneE.
    nDone = 0; d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    @(posedge CLK); #1;
    StartE = 1'b1; MulDivOpE = 3'd0; SrcAE = 32'd6; SrcBE = 32'd7;
    for (int k = 0; k < 80; k++) begin
      @(negedge CLK);
      if (DoneE) begin
        nDone++;
        if (nDone == 1) begin d1 = k; r1 = MulDivResultE; end
        else begin d2 = k; r2 = MulDivResultE; end
      end
      @(posedge CLK); #1;
      if (k == 0) begin MulDivOpE = 3'd4; SrcAE = 32'd100; SrcBE = 32'hFFFF_FFF9; end
      if (k == 34) StartE = 1'b0;
    end
    check("b2b_count", nDone, 32'd2);
    check("b2b_first_cycle", d1, 32'd33);
    check("b2b_second_cycle", d2, 32'd67);
    check("b2b_mul", r1, 32'd42);
    check("b2b_div", r2, 32'hFFFF_FFF2);

    // Flush during CALC.
    @(posedge CLK); #1;
    StartE = 1'b1; MulDivOpE = 3'd4; SrcAE = 32'd1000; SrcBE = 32'd3;
    repeat (10) begin @(posedge CLK); #1; StartE = 1'b0; end
    FlushE = 1'b1;
    @(negedge CLK);
    check("flush_stall", {31'b0, StallE}, 32'd0);
    @(posedge CLK); #1;
    FlushE = 1'b0;
    @(negedge CLK);
    check("flush_busy", {31'b0, Busy}, 32'd0);
    flushDones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DoneE) flushDones++;
    end
    check("flush_no_done", flushDones, 32'd0);

    // Asynchronous reset mid-MULH.
    @(posedge CLK); #1;
    StartE = 1'b1; MulDivOpE = 3'd1; SrcAE = 32'h1234_5678; SrcBE = 32'h9ABC_DEF0;
    repeat (15) begin @(posedge CLK); #1; StartE = 1'b0; end
    #1 Rst = 1'b0;
    #1;
    check("arst_stall", {31'b0, StallE}, 32'd0);
    check("arst_done", {31'b0, DoneE}, 32'd0);
    check("arst_busy", {31'b0, Busy}, 32'd0);
    check("arst_result", MulDivResultE, 32'd0);
    @(posedge CLK); #1;
    Rst = 1'b1;
    runOp("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // Random traffic with flushes, starts during busy, and special operands.
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK); #1;
      StartE    = ($urandom_range(0, 3) == 0);
      MulDivOpE = 3'($urandom_range(0, 7));
      SrcAE     = pickOperand();
      SrcBE     = pickOperand();
      FlushE    = ($urandom_range(0, 24) == 0);
    end
    @(posedge CLK); #1;
    StartE = 1'b0; FlushE = 1'b0;
    repeat (40) @(posedge CLK);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
